// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared RV32I decode constants and forwarding-source encoding.
package pipeline_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  typedef enum logic [1:0] {FWD_RF, FWD_MEM, FWD_WB} fwd_sel_e;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the freshest value of one source register; MEM beats WB, x0 is never forwarded.
module fwd_mux
  import pipeline_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [4:0]   i_rs_addr,
  input  logic [W-1:0] i_rf_data,
  input  logic [4:0]   i_mem_rd_addr,
  input  logic         i_mem_rd_wren,
  input  logic [W-1:0] i_mem_data,
  input  logic [4:0]   i_wb_rd_addr,
  input  logic         i_wb_rd_wren,
  input  logic [W-1:0] i_wb_data,
  output logic [W-1:0] o_data,
  output fwd_sel_e     o_sel
);
  always_comb begin
    o_sel  = (i_mem_rd_wren && i_mem_rd_addr == i_rs_addr && i_rs_addr != 5'd0) ? FWD_MEM :
             (i_wb_rd_wren  && i_wb_rd_addr  == i_rs_addr && i_rs_addr != 5'd0) ? FWD_WB  : FWD_RF;
    o_data = o_sel == FWD_MEM ? i_mem_data : o_sel == FWD_WB ? i_wb_data : i_rf_data;
  end
endmodule

// File: rtl/idex_shift_stage.sv
// idex_shift_stage: ID/EX register with shift decode and MEM/WB operand forwarding feeding the EX barrel shifter.
module idex_shift_stage
  import pipeline_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_id_valid,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [31:0]     i_id_instr,
  input  logic [XLEN-1:0] i_id_rs1_data,
  input  logic [XLEN-1:0] i_id_rs2_data,
  input  logic [4:0]      i_mem_rd_addr,
  input  logic            i_mem_rd_wren,
  input  logic [XLEN-1:0] i_mem_alu_data,
  input  logic [4:0]      i_wb_rd_addr,
  input  logic            i_wb_rd_wren,
  input  logic [XLEN-1:0] i_wb_rd_data,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [31:0]     o_ex_instr,
  output logic [4:0]      o_ex_rd_addr,
  output logic            o_ex_rd_wren,
  output logic            o_ex_is_shift,
  output logic [XLEN-1:0] o_shift_data_in,
  output logic            o_shift_rightleft,
  output logic            o_shift_arith,
  output logic [4:0]      o_shift_amount,
  output logic [XLEN-1:0] o_ex_rs2_fwd
);
  logic            valid_q, valid_d, rd_wren_q, rd_wren_d, is_shift_q, is_shift_d;
  logic            rightleft_q, rightleft_d, arith_q, arith_d;
  logic [XLEN-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [31:0]     instr_q, instr_d;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic            is_alu, sll, srl, sra, dec_shift, bubble, hold;
  fwd_sel_e        rs1_sel_unused, rs2_sel_unused;
  // An invalid ID slot loads exactly like a flush so EX never sees stale fields.
  always_comb begin
    opc         = i_id_instr[6:0];
    f3          = i_id_instr[14:12];
    f7          = i_id_instr[31:25];
    is_alu      = opc == OPC_OP || opc == OPC_OP_IMM;
    sll         = f3 == F3_SLL && f7 == F7_BASE;
    srl         = f3 == F3_SRL_SRA && f7 == F7_BASE;
    sra         = f3 == F3_SRL_SRA && f7 == F7_ALT;
    dec_shift   = is_alu && (sll || srl || sra);
    bubble      = i_flush || !i_id_valid;
    hold        = i_stall && !i_flush;
    valid_d     = hold ? valid_q     : !bubble;
    pc_d        = hold ? pc_q        : bubble ? '0 : i_id_pc;
    instr_d     = hold ? instr_q     : bubble ? NOP_INSTR : i_id_instr;
    rs1_data_d  = hold ? rs1_data_q  : bubble ? '0 : i_id_rs1_data;
    rs2_data_d  = hold ? rs2_data_q  : bubble ? '0 : i_id_rs2_data;
    rd_wren_d   = hold ? rd_wren_q   : !bubble && i_id_instr[11:7] != 5'd0;
    is_shift_d  = hold ? is_shift_q  : !bubble && dec_shift;
    rightleft_d = hold ? rightleft_q : !bubble && dec_shift && (srl || sra);
    arith_d     = hold ? arith_q     : !bubble && dec_shift && sra;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      instr_q     <= NOP_INSTR;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rd_wren_q   <= 1'b0;
      is_shift_q  <= 1'b0;
      rightleft_q <= 1'b0;
      arith_q     <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rd_wren_q   <= rd_wren_d;
      is_shift_q  <= is_shift_d;
      rightleft_q <= rightleft_d;
      arith_q     <= arith_d;
    end
  end
  fwd_mux #(.W(XLEN)) u_rs1_fwd (
    .i_rs_addr    (instr_q[19:15]),
    .i_rf_data    (rs1_data_q),
    .i_mem_rd_addr(i_mem_rd_addr),
    .i_mem_rd_wren(i_mem_rd_wren),
    .i_mem_data   (i_mem_alu_data),
    .i_wb_rd_addr (i_wb_rd_addr),
    .i_wb_rd_wren (i_wb_rd_wren),
    .i_wb_data    (i_wb_rd_data),
    .o_data       (o_shift_data_in),
    .o_sel        (rs1_sel_unused)
  );
  fwd_mux #(.W(XLEN)) u_rs2_fwd (
    .i_rs_addr    (instr_q[24:20]),
    .i_rf_data    (rs2_data_q),
    .i_mem_rd_addr(i_mem_rd_addr),
    .i_mem_rd_wren(i_mem_rd_wren),
    .i_mem_data   (i_mem_alu_data),
    .i_wb_rd_addr (i_wb_rd_addr),
    .i_wb_rd_wren (i_wb_rd_wren),
    .i_wb_data    (i_wb_rd_data),
    .o_data       (o_ex_rs2_fwd),
    .o_sel        (rs2_sel_unused)
  );
  assign o_ex_valid        = valid_q;
  assign o_ex_pc           = pc_q;
  assign o_ex_instr        = instr_q;
  assign o_ex_rd_addr      = instr_q[11:7];
  assign o_ex_rd_wren      = rd_wren_q;
  assign o_ex_is_shift     = is_shift_q;
  assign o_shift_rightleft = rightleft_q;
  assign o_shift_arith     = arith_q;
  assign o_shift_amount    = instr_q[6:0] == OPC_OP_IMM ? instr_q[24:20] : o_ex_rs2_fwd[4:0];
endmodule

// File: tb/tb_idex_shift_stage.sv
// tb_idex_shift_stage: directed vector table, stall/flush/reset sequences and random traffic against a spec-level model.
module tb_idex_shift_stage;
  localparam logic [6:0]  OP  = 7'b0110011;
  localparam logic [6:0]  OPI = 7'b0010011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0, i_rst_n = 1'b1, i_stall = 1'b0, i_flush = 1'b0, i_id_valid = 1'b0;
  logic [31:0] i_id_pc = '0, i_id_instr = '0, i_id_rs1_data = '0, i_id_rs2_data = '0;
  logic [4:0]  i_mem_rd_addr = '0, i_wb_rd_addr = '0;
  logic        i_mem_rd_wren = 1'b0, i_wb_rd_wren = 1'b0;
  logic [31:0] i_mem_alu_data = '0, i_wb_rd_data = '0;
  logic        o_ex_valid, o_ex_rd_wren, o_ex_is_shift, o_shift_rightleft, o_shift_arith;
  logic [31:0] o_ex_pc, o_ex_instr, o_shift_data_in, o_ex_rs2_fwd;
  logic [4:0]  o_ex_rd_addr, o_shift_amount;

  idex_shift_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_id_valid(i_id_valid), .i_id_pc(i_id_pc), .i_id_instr(i_id_instr),
    .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
    .i_mem_rd_addr(i_mem_rd_addr), .i_mem_rd_wren(i_mem_rd_wren), .i_mem_alu_data(i_mem_alu_data),
    .i_wb_rd_addr(i_wb_rd_addr), .i_wb_rd_wren(i_wb_rd_wren), .i_wb_rd_data(i_wb_rd_data),
    .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_instr(o_ex_instr),
    .o_ex_rd_addr(o_ex_rd_addr), .o_ex_rd_wren(o_ex_rd_wren), .o_ex_is_shift(o_ex_is_shift),
    .o_shift_data_in(o_shift_data_in), .o_shift_rightleft(o_shift_rightleft),
    .o_shift_arith(o_shift_arith), .o_shift_amount(o_shift_amount), .o_ex_rs2_fwd(o_ex_rs2_fwd)
  );

  always #5 i_clk = ~i_clk;

  int errs = 0, checks = 0;

  typedef struct {
    bit          v;
    logic [31:0] pc, instr, r1, r2;
  } ex_t;
  ex_t m;

  typedef struct {
    logic [31:0] instr, r1, r2;
    logic [4:0]  mrd;
    logic        mw;
    logic [31:0] md;
    logic [4:0]  wrd;
    logic        ww;
    logic [31:0] wd;
    logic        e_shift, e_rl, e_ar, e_wren;
    logic [4:0]  e_amt;
    logic [31:0] e_din;
  } vec_t;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic ex_t bubble_rec();
    ex_t b;
    b.v = 1'b0; b.pc = '0; b.instr = NOP; b.r1 = '0; b.r2 = '0;
    return b;
  endfunction

  function automatic string mnem(ex_t e);
    logic [2:0] f3 = e.instr[14:12];
    logic [6:0] f7 = e.instr[31:25];
    string sfx;
    if (!e.v) return "";
    if (e.instr[6:0] == OP) sfx = "";
    else if (e.instr[6:0] == OPI) sfx = "I";
    else return "";
    if (f3 == 3'd1 && f7 == 7'h00) return {"SLL", sfx};
    if (f3 == 3'd5 && f7 == 7'h00) return {"SRL", sfx};
    if (f3 == 3'd5 && f7 == 7'h20) return {"SRA", sfx};
    return "";
  endfunction

  function automatic logic [31:0] fwd(logic [4:0] rs, logic [31:0] rf);
    if (rs == 5'd0) return rf;
    if (i_mem_rd_wren && i_mem_rd_addr == rs) return i_mem_alu_data;
    if (i_wb_rd_wren && i_wb_rd_addr == rs) return i_wb_rd_data;
    return rf;
  endfunction

  task automatic model_edge();
    if (i_flush) m = bubble_rec();
    else if (!i_stall) begin
      if (!i_id_valid) m = bubble_rec();
      else begin
        m.v = 1'b1; m.pc = i_id_pc; m.instr = i_id_instr; m.r1 = i_id_rs1_data; m.r2 = i_id_rs2_data;
      end
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(string tag);
    string       mn = mnem(m);
    logic [31:0] r2f = fwd(m.instr[24:20], m.r2);
    chk({tag, ".valid"}, o_ex_valid, m.v);
    chk({tag, ".pc"}, o_ex_pc, m.pc);
    chk({tag, ".instr"}, o_ex_instr, m.instr);
    chk({tag, ".rd"}, o_ex_rd_addr, m.instr[11:7]);
    chk({tag, ".wren"}, o_ex_rd_wren, m.v && m.instr[11:7] != 5'd0);
    chk({tag, ".shift"}, o_ex_is_shift, mn != "");
    chk({tag, ".rl"}, o_shift_rightleft, mn.substr(0, 1) == "SR");
    chk({tag, ".ar"}, o_shift_arith, mn.substr(0, 2) == "SRA");
    chk({tag, ".din"}, o_shift_data_in, fwd(m.instr[19:15], m.r1));
    chk({tag, ".rs2"}, o_ex_rs2_fwd, r2f);
    if (m.instr[6:0] == OPI) chk({tag, ".amt"}, o_shift_amount, m.instr[24:20]);
    else if (m.instr[6:0] == OP) chk({tag, ".amt"}, o_shift_amount, r2f[4:0]);
  endtask

  task automatic load(logic [31:0] instr, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2);
    i_id_valid = 1'b1; i_id_instr = instr; i_id_pc = pc; i_id_rs1_data = r1; i_id_rs2_data = r2;
  endtask

  initial begin
    vec_t vt[7];
    vt[0] = '{32'h4043_5293, 32'h8000_0000, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
              1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h8000_0000};
    vt[1] = '{enc(7'h00, 5'd2, 5'd1, 3'd1, 5'd3, OP), 32'h0000_00AA, 32'h0000_0123,
              5'd2, 1'b1, 32'h0000_0007, 5'd2, 1'b1, 32'h0000_001F,
              1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_00AA};
    vt[2] = '{enc(7'h00, 5'd2, 5'd0, 3'd5, 5'd4, OP), 32'h0, 32'h0000_0025,
              5'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'hFFFF_FFFF,
              1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0};
    vt[3] = '{enc(7'h01, 5'd3, 5'd1, 3'd1, 5'd7, OPI), 32'h0000_0011, 32'h0,
              5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0011};
    vt[4] = '{enc(7'h20, 5'd2, 5'd1, 3'd5, 5'd9, OP), 32'hF000_0000, 32'h0,
              5'd3, 1'b1, 32'h1234_5678, 5'd2, 1'b1, 32'h0000_003F,
              1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 32'hF000_0000};
    vt[5] = '{enc(7'h00, 5'd8, 5'd5, 3'd5, 5'd0, OPI), 32'h0000_0100, 32'h0,
              5'd5, 1'b0, 32'hDEAD_BEEF, 5'd5, 1'b1, 32'h0000_0200,
              1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_0200};
    vt[6] = '{enc(7'h21, 5'd2, 5'd1, 3'd5, 5'd1, OPI), 32'h0000_0005, 32'h0,
              5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0005};

    #1 i_rst_n = 1'b0;
    m = bubble_rec();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check_all("reset");

    // load SRAI, then assert reset in the middle of a cycle
    load(32'h4043_5293, 32'h0000_0040, 32'h8000_0000, 32'h0);
    cycle();
    check_all("srai_pre_rst");
    i_stall = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    m = bubble_rec();
    chk("arst.valid", o_ex_valid, 1'b0);
    chk("arst.instr", o_ex_instr, NOP);
    chk("arst.pc", o_ex_pc, 32'h0);
    chk("arst.shift", o_ex_is_shift, 1'b0);
    chk("arst.rl", o_shift_rightleft, 1'b0);
    chk("arst.ar", o_shift_arith, 1'b0);
    chk("arst.amt", o_shift_amount, 5'd0);
    chk("arst.din", o_shift_data_in, 32'h0);
    chk("arst.wren", o_ex_rd_wren, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1; i_stall = 1'b0;

    for (int i = 0; i < 7; i++) begin
      string t = $sformatf("vec%0d", i);
      @(negedge i_clk);
      load(vt[i].instr, 32'h100 + 32'(i * 4), vt[i].r1, vt[i].r2);
      i_mem_rd_addr = vt[i].mrd; i_mem_rd_wren = vt[i].mw; i_mem_alu_data = vt[i].md;
      i_wb_rd_addr = vt[i].wrd; i_wb_rd_wren = vt[i].ww; i_wb_rd_data = vt[i].wd;
      cycle();
      chk({t, ".shift"}, o_ex_is_shift, vt[i].e_shift);
      chk({t, ".rl"}, o_shift_rightleft, vt[i].e_rl);
      chk({t, ".ar"}, o_shift_arith, vt[i].e_ar);
      chk({t, ".wren"}, o_ex_rd_wren, vt[i].e_wren);
      chk({t, ".amt"}, o_shift_amount, vt[i].e_amt);
      chk({t, ".din"}, o_shift_data_in, vt[i].e_din);
      check_all({t, ".model"});
    end

    // stall three cycles with new ID contents, then flush while still stalled
    @(negedge i_clk);
    i_mem_rd_wren = 1'b0; i_wb_rd_wren = 1'b0;
    load(enc(7'h00, 5'd2, 5'd1, 3'd5, 5'd6, OP), 32'h0000_0200, 32'h0000_0F00, 32'h0000_0004);
    cycle();
    @(negedge i_clk);
    i_stall = 1'b1;
    load(enc(7'h00, 5'd3, 5'd3, 3'd1, 5'd8, OP), 32'h0000_0300, 32'h1, 32'h1);
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk($sformatf("stall%0d.instr", c), o_ex_instr, enc(7'h00, 5'd2, 5'd1, 3'd5, 5'd6, OP));
      chk($sformatf("stall%0d.pc", c), o_ex_pc, 32'h0000_0200);
      chk($sformatf("stall%0d.valid", c), o_ex_valid, 1'b1);
    end
    i_mem_rd_addr = 5'd1; i_mem_rd_wren = 1'b1; i_mem_alu_data = 32'hCAFE_0000;
    #1 chk("stall.live_fwd", o_shift_data_in, 32'hCAFE_0000);
    @(negedge i_clk);
    i_flush = 1'b1;
    cycle();
    chk("flush.valid", o_ex_valid, 1'b0);
    chk("flush.shift", o_ex_is_shift, 1'b0);
    chk("flush.instr", o_ex_instr, NOP);
    chk("flush.pc", o_ex_pc, 32'h0);
    @(negedge i_clk);
    i_flush = 1'b0; i_stall = 1'b0; i_id_valid = 1'b0;
    cycle();
    chk("invalid.valid", o_ex_valid, 1'b0);
    chk("invalid.instr", o_ex_instr, NOP);

    for (int n = 0; n < 400; n++) begin
      logic [6:0] opc, f7;
      logic [2:0] f3;
      @(negedge i_clk);
      case ($urandom_range(0, 3))
        0: opc = OP;
        1, 2: opc = OPI;
        default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0: f3 = 3'd1;
        1: f3 = 3'd5;
        default: f3 = 3'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1: f7 = 7'h00;
        2: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      i_id_instr = enc(f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3,
                       5'($urandom_range(0, 3)), opc);
      i_id_pc = $urandom; i_id_rs1_data = $urandom; i_id_rs2_data = $urandom;
      i_id_valid = $urandom_range(0, 5) != 0;
      i_stall = $urandom_range(0, 3) == 0;
      i_flush = $urandom_range(0, 7) == 0;
      i_mem_rd_addr = 5'($urandom_range(0, 3)); i_mem_rd_wren = 1'($urandom); i_mem_alu_data = $urandom;
      i_wb_rd_addr = 5'($urandom_range(0, 3)); i_wb_rd_wren = 1'($urandom); i_wb_rd_data = $urandom;
      cycle();
      check_all($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
